// File: rtl/tc141_pipex.sv
// Elastic DEPTH-stage valid/ready pipeline with bubble collapsing and synchronous flush.
// Optional occupancy counter output o_cnt is built when TC141_PIPEX_CNT_EN is defined.
module tc141_pipex #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               RESET_ENB   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             flush,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] idat,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] odat
`ifdef TC141_PIPEX_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
`endif
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] adv_c;
  logic [DEPTH-1:0] src_vld_c;
  logic             adv_chain_c;
  logic [WIDTH-1:0] dat_q     [DEPTH] = '{default: RESET_VALUE};
  logic [WIDTH-1:0] dat_d     [DEPTH];
  logic [WIDTH-1:0] src_dat_c [DEPTH];

  // Advance chain: a stage may load when it is empty or everything downstream moves.
  always_comb begin
    adv_c       = '0;
    adv_chain_c = o_rdy;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      adv_chain_c = !vld_q[k] | adv_chain_c;
      adv_c[k]    = adv_chain_c;
    end
  end

  // Source of each stage: upstream port for stage 0, previous stage otherwise.
  always_comb begin
    src_vld_c[0] = i_vld;
    src_dat_c[0] = idat;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      src_vld_c[k] = vld_q[k-1];
      src_dat_c[k] = dat_q[k-1];
    end
  end

  // Next state; data only moves with a valid source so bubbles never clobber it.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (adv_c[k]) begin
        vld_d[k] = src_vld_c[k];
        if (src_vld_c[k]) begin
          dat_d[k] = src_dat_c[k];
        end
      end
    end
    if (flush) begin
      vld_d = '0;
      dat_d = dat_q;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  generate
    if (RESET_ENB) begin : g_dat_rst
      always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            dat_q[k] <= RESET_VALUE;
          end
        end else begin
          dat_q <= dat_d;
        end
      end
    end else begin : g_dat_norst
      always_ff @(posedge clk) begin
        dat_q <= dat_d;
      end
    end
  endgenerate

  assign i_rdy = adv_c[0];
  assign o_vld = vld_q[DEPTH-1];
  assign odat  = dat_q[DEPTH-1];

`ifdef TC141_PIPEX_CNT_EN
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic          in_xfer_c;
  logic          out_xfer_c;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign in_xfer_c  = i_vld & adv_c[0];
  assign out_xfer_c = vld_q[DEPTH-1] & o_rdy;

  // Occupancy tracks transfers; flush empties the pipe.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (in_xfer_c && !out_xfer_c) begin
      cnt_d = cnt_q + CW'(1);
    end else if (out_xfer_c && !in_xfer_c) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tc141_pipex.sv
// Directed bench for tc141_pipex (WIDTH=8, DEPTH=3, data reset to 0xA5).
module tb_tc141_pipex;

  logic       clk = 1'b0;
  logic       rst_;
  logic       flush;
  logic       i_vld;
  logic       i_rdy;
  logic [7:0] idat;
  logic       o_vld;
  logic       o_rdy;
  logic [7:0] odat;
`ifdef TC141_PIPEX_CNT_EN
  logic [1:0] o_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tc141_pipex #(
    .WIDTH      (8),
    .DEPTH      (3),
    .RESET_VALUE(8'hA5),
    .RESET_ENB  (1'b1)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .flush(flush),
    .i_vld(i_vld),
    .i_rdy(i_rdy),
    .idat (idat),
    .o_vld(o_vld),
    .o_rdy(o_rdy),
    .odat (odat)
`ifdef TC141_PIPEX_CNT_EN
    ,
    .o_cnt(o_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int unsigned exp);
`ifdef TC141_PIPEX_CNT_EN
    chk(tag, 32'(o_cnt), 32'(exp));
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] word;

  initial begin
    rst_  = 1'b1;
    flush = 1'b0;
    i_vld = 1'b0;
    o_rdy = 1'b0;
    idat  = 8'h00;
    #12;
    chk("rst_o_vld", 32'(o_vld), 32'd0);
    chk("rst_i_rdy", 32'(i_rdy), 32'd1);
    chk("rst_odat", 32'(odat), 32'hA5);
    chk_cnt("rst_cnt", 0);
    rst_ = 1'b0;
    tick();

    // Streaming 0x01..0x0A with o_rdy held high
    for (int c = 0; c < 14; c++) begin
      o_rdy = 1'b1;
      i_vld = (c < 10);
      idat  = 8'(c + 1);
      #1;
      chk("stream_i_rdy", 32'(i_rdy), 32'd1);
      tick();
      chk("stream_o_vld", 32'(o_vld), 32'((c >= 2) && (c < 12)));
      if ((c >= 2) && (c < 12)) chk("stream_odat", 32'(odat), 32'(c - 1));
    end

    // Stall: five words offered into a blocked pipe
    i_vld = 1'b0;
    o_rdy = 1'b0;
    for (int a = 0; a < 5; a++) begin
      i_vld = 1'b1;
      idat  = (a < 3) ? 8'(a + 1) : 8'd4;
      #1;
      chk("stall_i_rdy", 32'(i_rdy), 32'(a < 3));
      tick();
    end
    chk_cnt("stall_cnt_full", 3);
    chk("stall_o_vld", 32'(o_vld), 32'd1);
    chk("stall_odat", 32'(odat), 32'd1);
    for (int j = 0; j < 5; j++) begin
      o_rdy = 1'b1;
      i_vld = (j < 2);
      idat  = 8'(4 + j);
      #1;
      chk("drain_o_vld", 32'(o_vld), 32'd1);
      chk("drain_odat", 32'(odat), 32'(j + 1));
      chk("passthru_i_rdy", 32'(i_rdy), 32'd1);
      chk_cnt("passthru_cnt", (j <= 2) ? 3 : 5 - j);
      tick();
    end
    i_vld = 1'b0;
    chk("drain_empty", 32'(o_vld), 32'd0);
    chk_cnt("drain_cnt", 0);

    // Flush a full pipe while a word is offered
    o_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_vld = 1'b1;
      idat  = 8'(8'h11 * (k + 1));
      tick();
    end
    i_vld = 1'b0;
    chk_cnt("fill_cnt", 3);
    chk("fill_o_vld", 32'(o_vld), 32'd1);
    chk("fill_odat", 32'(odat), 32'h11);
    flush = 1'b1;
    i_vld = 1'b1;
    idat  = 8'h44;
    o_rdy = 1'b1;
    tick();
    flush = 1'b0;
    i_vld = 1'b0;
    chk("flush_o_vld", 32'(o_vld), 32'd0);
    chk_cnt("flush_cnt", 0);
    chk("flush_odat_kept", 32'(odat), 32'h11);
    chk("flush_i_rdy", 32'(i_rdy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_dropped", 32'(o_vld), 32'd0);
    end
    i_vld = 1'b1;
    idat  = 8'h55;
    tick();
    i_vld = 1'b0;
    tick();
    tick();
    chk("post_flush_o_vld", 32'(o_vld), 32'd1);
    chk("post_flush_odat", 32'(odat), 32'h55);
    tick();
    chk("post_flush_empty", 32'(o_vld), 32'd0);

    // Asynchronous reset with two words in flight
    i_vld = 1'b1;
    idat  = 8'h66;
    tick();
    idat  = 8'h77;
    tick();
    i_vld = 1'b0;
    tick();
    chk("pre_rst_o_vld", 32'(o_vld), 32'd1);
    chk("pre_rst_odat", 32'(odat), 32'h66);
    #3;
    rst_ = 1'b1;
    #1;
    chk("arst_o_vld", 32'(o_vld), 32'd0);
    chk("arst_odat", 32'(odat), 32'hA5);
    chk("arst_i_rdy", 32'(i_rdy), 32'd1);
    chk_cnt("arst_cnt", 0);
    tick();
    chk("arst_hold_o_vld", 32'(o_vld), 32'd0);
    rst_  = 1'b0;
    i_vld = 1'b1;
    idat  = 8'h88;
    tick();
    i_vld = 1'b0;
    tick();
    tick();
    chk("post_rst_o_vld", 32'(o_vld), 32'd1);
    chk("post_rst_odat", 32'(odat), 32'h88);
    tick();
    chk("post_rst_empty", 32'(o_vld), 32'd0);

    // Bubble pattern: alternating i_vld, random o_rdy, scoreboard on every transfer
    word = 8'h00;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      i_vld = ((cyc % 2) == 0);
      o_rdy = 1'($urandom_range(0, 1));
      idat  = word;
      #1;
      chk("bubble_i_rdy", 32'(i_rdy), 32'(!((q.size() == 3) && !o_rdy)));
      chk_cnt("bubble_cnt", q.size());
      if (q.size() == 0) begin
        chk("bubble_empty_o_vld", 32'(o_vld), 32'd0);
      end else if (o_vld && o_rdy) begin
        chk("bubble_odat", 32'(odat), 32'(q.pop_front()));
      end
      if (i_vld && i_rdy) begin
        q.push_back(idat);
        word = word + 8'd1;
      end
      tick();
    end
    i_vld = 1'b0;
    o_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (o_vld) begin
        if (q.size() == 0) chk("drain_extra", 32'(o_vld), 32'd0);
        else chk("drain_odat_sb", 32'(odat), 32'(q.pop_front()));
      end
      tick();
    end
    chk("bubble_lost", 32'(q.size()), 32'd0);
    chk("bubble_final_o_vld", 32'(o_vld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tc141_pipex.md
TC141_PIPEX -- requirements
Module: tc141_pipex

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal range 1..1024.
REQ-002 SHALL have parameter DEPTH, default 2: number of pipeline stages, legal range 1..32.
REQ-003 SHALL have parameter RESET_VALUE, default all-zero WIDTH bits: value loaded into data registers on reset.
REQ-004 SHALL have parameter RESET_ENB, default 0: 1 = data registers reset by rst_, 0 = data registers not reset.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst_, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port flush, input, 1: synchronous clear of all stage valids.
REQ-008 SHALL have port i_vld, input, 1: upstream data valid.
REQ-009 SHALL have port i_rdy, output, 1: stage 0 can accept this cycle.
REQ-010 SHALL have port idat, input, WIDTH: upstream data.
REQ-011 SHALL have port o_vld, output, 1: last stage holds valid data.
REQ-012 SHALL have port o_rdy, input, 1: downstream accepts this cycle.
REQ-013 SHALL have port odat, output, WIDTH: last-stage data.
REQ-014 SHALL have port o_cnt, output, clog2(DEPTH+1): occupied stage count, present only when TC141_PIPEX_CNT_EN is defined.

Function
REQ-015 SHALL implement DEPTH stages; stage k holds vld[k] and dat[k]; stage 0 is input side and stage DEPTH-1 drives o_vld/odat.
REQ-016 SHALL define adv[DEPTH-1] = !vld[DEPTH-1] | o_rdy, and adv[k] = !vld[k] | adv[k+1] for k < DEPTH-1.
REQ-017 SHALL drive i_rdy = adv[0] combinationally; a transfer in occurs when i_vld & i_rdy.
REQ-018 SHALL load stage k from stage k-1 (stage 0 from idat/i_vld) on a clock edge when adv[k] = 1; SHALL hold stage k when adv[k] = 0.
REQ-019 SHALL update dat[k] only when its source valid is 1 and adv[k] = 1; bubbles SHALL NOT overwrite data.
REQ-020 SHALL give latency DEPTH cycles from input transfer to o_vld with o_rdy held 1, and throughput one word per cycle.
REQ-021 SHALL collapse bubbles: while o_rdy = 0, accept input until all DEPTH stages are valid, then drive i_rdy = 0.
REQ-022 SHALL preserve order and lose or duplicate no word under any i_vld/o_rdy pattern.
REQ-023 SHALL treat flush as highest priority: on a flush edge all vld[k] become 0, any concurrent input or output transfer is discarded, and dat[k] is unchanged.
REQ-024 SHALL drive odat = dat[DEPTH-1] regardless of o_vld.
REQ-025 SHALL let a full pipe with o_rdy = 1 accept a new word in the same cycle that it outputs one (i_rdy = 1).

Reset
REQ-026 SHALL clear all vld[k] to 0 asynchronously when rst_ = 1, including mid-transfer; o_vld = 0 and i_rdy = 1 while in reset.
REQ-027 SHALL load all dat[k] with RESET_VALUE on rst_ when RESET_ENB = 1; SHALL leave dat[k] unreset when RESET_ENB = 0 but initialise them to RESET_VALUE.
REQ-028 SHALL resume normal operation on the first clock edge after rst_ deasserts.

Configuration
REQ-029 SHALL, with TC141_PIPEX_CNT_EN defined, provide o_cnt = number of valid stages: reset 0; +1 on input transfer only; -1 on output transfer only; unchanged when both or neither occur; 0 on flush.
REQ-030 SHALL, without TC141_PIPEX_CNT_EN, omit the o_cnt port and its counter logic entirely; pipeline behaviour SHALL be identical in both builds.

Verification
REQ-031 SHALL test streaming: WIDTH=8, DEPTH=3, o_rdy=1, inputs 0x01..0x0A on consecutive cycles -> same sequence on odat starting 3 cycles later, o_vld contiguous for 10 cycles.
REQ-032 SHALL test stall: DEPTH=3, o_rdy=0, 5 words offered -> i_rdy drops after 3 accepted, o_cnt=3; o_rdy=1 -> words 1..5 emerge in order.
REQ-033 SHALL test a bubble pattern: alternating i_vld and random o_rdy over 1000 cycles -> scoreboard shows no loss, duplication or reorder.
REQ-034 SHALL test flush: full pipe, flush pulsed with i_vld=1 -> next cycle o_vld=0, o_cnt=0, the offered word is dropped.
REQ-035 SHALL test reset mid-stream: rst_ asserted asynchronously between edges with 2 words in flight -> o_vld=0 immediately; with RESET_ENB=1 and RESET_VALUE=0xA5, odat=0xA5.
REQ-036 SHALL test full-pipe pass-through: pipe full, o_rdy=1, i_vld=1 -> i_rdy=1 and o_cnt stays at DEPTH.
